clint_ipi_arbiter: RTL and testbench

CLINT_IPI_ARBITER -- requirements
Module: clint_ipi_arbiter

---
 rtl/clint_pkg.sv | 38 +++
 rtl/clint_ipi_arbiter_rr_arb2.sv | 38 +++
 rtl/clint_ipi_arbiter.sv | 175 +++++++++++++++++
 tb/tb_clint_ipi_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clint_pkg
// Brief    : Shared CLINT IPI constants, AXI response codes and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package clint_pkg;

    localparam logic [31:0] CLINT_MSIP0_ADDR = 32'h0200_0000;
    localparam logic [31:0] CLINT_MSIP1_ADDR = 32'h0200_0004;
    localparam logic [31:0] CLINT_SSIP0_ADDR = 32'h0200_C000;
    localparam logic [31:0] CLINT_SSIP1_ADDR = 32'h0200_C004;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } ipi_state_t;

    // Anything other than OKAY is reported as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY:   err = 1'b0;
            AXI_RESP_EXOKAY: err = 1'b1;
            AXI_RESP_SLVERR: err = 1'b1;
            AXI_RESP_DECERR: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clint_ipi_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; pointer advances only on accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       aclk,
    input  logic       areset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Reset to 1 so requester 0 wins the first contention.
    logic r_last_id;

    always_comb begin
        grant_id = 1'b0;
        if (req[0] && req[1]) begin
            grant_id = ~r_last_id;
        end else begin
            grant_id = req[1];
        end
        grant = {req[1] & grant_id, req[0] & ~grant_id};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_last_id <= 1'b1;
        end else if (accept) begin
            r_last_id <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clint_ipi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : clint_ipi_arbiter
// Brief    : Arbitrates two IPI requesters onto one AXI write master (1 outstanding).
// Revision : 1.0 - initial release
// ============================================================================
module clint_ipi_arbiter
    import clint_pkg::*;
#(
    parameter logic [31:0] MSIP0_ADDR = CLINT_MSIP0_ADDR,
    parameter logic [31:0] MSIP1_ADDR = CLINT_MSIP1_ADDR,
    parameter logic [31:0] SSIP0_ADDR = CLINT_SSIP0_ADDR,
    parameter logic [31:0] SSIP1_ADDR = CLINT_SSIP1_ADDR
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        req0_valid,
    input  logic        req0_tgt,
    input  logic        req0_lvl,
    input  logic        req0_set,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic        rsp0_err,

    input  logic        req1_valid,
    input  logic        req1_tgt,
    input  logic        req1_lvl,
    input  logic        req1_set,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic        rsp1_err,

    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    ipi_state_t  r_state;
    ipi_state_t  w_state_nxt;

    logic        w_accept;
    logic        w_bready;
    logic [1:0]  w_grant;
    logic        w_grant_id;
    logic        w_aw_done;
    logic        w_w_done;

    logic        w_sel_tgt;
    logic        w_sel_lvl;
    logic        w_sel_set;
    logic [31:0] w_sel_addr;

    logic        r_id;
    logic        r_awvalid;
    logic        r_wvalid;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [1:0]  r_rsp_valid;
    logic [1:0]  r_rsp_err;

    rr_arb2 u_rr_arb2 (
        .aclk     (aclk),
        .areset   (areset),
        .req      ({req1_valid, req0_valid}),
        .accept   (w_accept),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    assign w_sel_tgt = w_grant_id ? req1_tgt : req0_tgt;
    assign w_sel_lvl = w_grant_id ? req1_lvl : req0_lvl;
    assign w_sel_set = w_grant_id ? req1_set : req0_set;

    always_comb begin
        w_sel_addr = MSIP0_ADDR;
        case ({w_sel_lvl, w_sel_tgt})
            2'b00: w_sel_addr = MSIP0_ADDR;
            2'b01: w_sel_addr = MSIP1_ADDR;
            2'b10: w_sel_addr = SSIP0_ADDR;
            2'b11: w_sel_addr = SSIP1_ADDR;
        endcase
    end

    // A channel counts as done if it already handshook or handshakes now.
    assign w_aw_done = ~r_awvalid | awready;
    assign w_w_done  = ~r_wvalid  | wready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((req0_valid || req1_valid) && !areset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_bready = 1'b1;
                if (bvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_id        <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            if (w_accept) begin
                r_id      <= w_grant_id;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= w_sel_addr;
                r_wdata   <= {31'b0, w_sel_set};
            end else begin
                if (r_awvalid && awready) r_awvalid <= 1'b0;
                if (r_wvalid && wready)   r_wvalid  <= 1'b0;
            end
            if (r_state == ST_RESP && bvalid) begin
                r_rsp_valid[r_id] <= 1'b1;
                r_rsp_err[r_id]   <= resp_is_err(bresp);
            end
        end
    end

    assign req0_ready = w_accept & w_grant[0];
    assign req1_ready = w_accept & w_grant[1];
    assign awaddr     = r_awaddr;
    assign awvalid    = r_awvalid;
    assign wdata      = r_wdata;
    assign wvalid     = r_wvalid;
    assign wlast      = r_wvalid;
    assign bready     = w_bready;
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp1_err   = r_rsp_err[1];

endmodule
`default_nettype wire

// File: tb/tb_clint_ipi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_ipi_arbiter
// Brief    : Directed bench with a transaction-level reference model for clint_ipi_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_ipi_arbiter;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req0_valid = 1'b0, req0_tgt = 1'b0, req0_lvl = 1'b0, req0_set = 1'b0;
    logic        req1_valid = 1'b0, req1_tgt = 1'b0, req1_lvl = 1'b0, req1_set = 1'b0;
    logic        req0_ready, rsp0_valid, rsp0_err;
    logic        req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] awaddr, wdata;
    logic        awvalid, wvalid, wlast, bready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    always #5 aclk = ~aclk;

    clint_ipi_arbiter dut (
        .aclk       (aclk),
        .areset     (areset),
        .req0_valid (req0_valid),
        .req0_tgt   (req0_tgt),
        .req0_lvl   (req0_lvl),
        .req0_set   (req0_set),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_tgt   (req1_tgt),
        .req1_lvl   (req1_lvl),
        .req1_set   (req1_set),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_err   (rsp1_err),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave behaviour knobs
    int         aw_delay = 0;
    int         w_delay  = 0;
    int         b_delay  = 0;
    logic [1:0] b_code   = 2'b00;

    // Reference model: one outstanding write, described as pending channels
    bit          m_busy = 1'b0;
    bit          m_aw   = 1'b0;
    bit          m_w    = 1'b0;
    bit          m_id   = 1'b0;
    bit          m_last = 1'b1;
    bit [1:0]    m_rsp  = 2'b00;
    bit          m_err  = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;

    // Observation log, written only by the compare process
    int          grant_q[$];
    int          t_grant = 0;
    int          t_rsp0 = 0, t_rsp1 = 0;
    int          rsp0_cnt = 0, rsp1_cnt = 0;
    bit          err0_seen = 1'b0, err1_seen = 1'b0;
    int          aw_cycles = 0, w_cycles = 0, b_hs = 0;
    logic [31:0] seen_addr = 32'h0, seen_wdata = 32'h0;
    logic [31:0] mem [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] addr_of(input bit tgt, input bit lvl);
        if (!lvl) return tgt ? 32'h0200_0004 : 32'h0200_0000;
        else      return tgt ? 32'h0200_C004 : 32'h0200_C000;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return (a[15:12] == 4'hC ? 2 : 0) + (a[2] ? 1 : 0);
    endfunction

    // Compare process: checks every cycle, then advances the model
    always @(negedge aclk) begin
        bit       gid;
        bit [1:0] exp_ready;
        bit       b_pend;
        cyc++;
        gid       = 1'b0;
        exp_ready = 2'b00;
        if (!m_busy && !areset && (req0_valid || req1_valid)) begin
            gid = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            exp_ready[gid] = 1'b1;
        end
        b_pend = m_busy && !m_aw && !m_w;

        chk("req0_ready", {31'b0, req0_ready}, {31'b0, exp_ready[0]});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, exp_ready[1]});
        chk("awvalid",    {31'b0, awvalid},    {31'b0, m_aw});
        chk("wvalid",     {31'b0, wvalid},     {31'b0, m_w});
        chk("wlast",      {31'b0, wlast},      {31'b0, m_w});
        chk("bready",     {31'b0, bready},     {31'b0, b_pend});
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_rsp[0]});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_rsp[1]});
        chk("rsp0_err",   {31'b0, rsp0_err},   {31'b0, m_rsp[0] & m_err});
        chk("rsp1_err",   {31'b0, rsp1_err},   {31'b0, m_rsp[1] & m_err});
        if (m_aw) chk("awaddr", awaddr, m_addr);
        if (m_w)  chk("wdata",  wdata,  m_wdata);

        if (req0_ready) begin grant_q.push_back(0); t_grant = cyc; end
        if (req1_ready) begin grant_q.push_back(1); t_grant = cyc; end
        if (awvalid) begin aw_cycles++; seen_addr = awaddr; end
        if (wvalid)  begin w_cycles++;  seen_wdata = wdata; end
        if (bvalid && bready) begin b_hs++; mem[idx_of(seen_addr)] = seen_wdata; end
        if (rsp0_valid) begin t_rsp0 = cyc; rsp0_cnt++; err0_seen = rsp0_err; end
        if (rsp1_valid) begin t_rsp1 = cyc; rsp1_cnt++; err1_seen = rsp1_err; end

        if (areset) begin
            m_busy = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_rsp = 2'b00;
            m_last = 1'b1; m_err = 1'b0;
        end else begin
            m_rsp = 2'b00;
            if (!m_busy) begin
                if (exp_ready != 2'b00) begin
                    m_busy  = 1'b1; m_aw = 1'b1; m_w = 1'b1;
                    m_id    = gid;  m_last = gid;
                    m_addr  = gid ? addr_of(req1_tgt, req1_lvl) : addr_of(req0_tgt, req0_lvl);
                    m_wdata = {31'b0, (gid ? req1_set : req0_set)};
                end
            end else begin
                if (m_aw && awready) m_aw = 1'b0;
                if (m_w && wready)   m_w  = 1'b0;
                if (b_pend && bvalid) begin
                    m_busy   = 1'b0;
                    m_rsp[m_id] = 1'b1;
                    m_err    = (bresp != 2'b00);
                end
            end
        end
    end

    // AXI slave with programmable ready / response delays
    initial begin
        int aw_cnt, w_cnt, b_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(posedge aclk); #1;
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            w_cnt   = wvalid  ? w_cnt + 1  : 0;
            b_cnt   = bready  ? b_cnt + 1  : 0;
            awready = awvalid && (aw_cnt > aw_delay);
            wready  = wvalid  && (w_cnt > w_delay);
            bvalid  = bready  && (b_cnt > b_delay);
            bresp   = bvalid ? b_code : 2'b00;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input bit n, input bit tgt, input bit lvl, input bit set);
        if (!n) begin req0_valid = 1'b1; req0_tgt = tgt; req0_lvl = lvl; req0_set = set; end
        else    begin req1_valid = 1'b1; req1_tgt = tgt; req1_lvl = lvl; req1_set = set; end
    endtask

    // Hold each raised request until its accept pulse has been seen
    task automatic send();
        int  k;
        bit  s0, s1;
        k = 0;
        while ((req0_valid || req1_valid) && k < 40) begin
            @(negedge aclk);
            s0 = req0_ready; s1 = req1_ready;
            @(posedge aclk); #1;
            if (s0) req0_valid = 1'b0;
            if (s1) req1_valid = 1'b0;
            k++;
        end
        if (req0_valid || req1_valid) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (m_busy && k < 60) begin step(1); k++; end
        if (m_busy) chk("response_timeout", 32'd1, 32'd0);
        step(2);
    endtask

    initial begin
        int base_aw, base_w, base_b, base_r1, base_q;

        areset = 1'b1;
        step(3);
        chk("rst_awaddr",  awaddr, 32'h0);
        chk("rst_wdata",   wdata,  32'h0);
        chk("rst_wlast",   {31'b0, wlast},   32'h0);
        chk("rst_awvalid", {31'b0, awvalid}, 32'h0);
        chk("rst_rsp_err", {30'b0, rsp1_err, rsp0_err}, 32'h0);
        areset = 1'b0;
        step(1);

        // Single write, zero-wait slave
        set_req(1'b0, 1'b1, 1'b0, 1'b1);
        send();
        wait_done();
        chk("t1_awaddr",  seen_addr, 32'h0200_0004);
        chk("t1_wdata",   seen_wdata, 32'h1);
        chk("t1_latency", t_rsp0 - t_grant, 32'd3);
        chk("t1_err",     {31'b0, err0_seen}, 32'h0);
        chk("t1_rsp_cnt", rsp0_cnt, 32'd1);

        // Contention straight after reset, both writing MSIP0
        areset = 1'b1; step(1); areset = 1'b0; step(1);
        base_q = grant_q.size();
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        send();
        wait_done();
        chk("t2_mem_last_wins_a", mem[0], 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 1'b1);
        send();
        wait_done();
        chk("t2_mem_last_wins_b", mem[0], 32'h1);
        chk("t2_grants", grant_q.size() - base_q, 32'd4);
        if (grant_q.size() - base_q == 4) begin
            chk("t2_grant0", grant_q[base_q],     32'd0);
            chk("t2_grant1", grant_q[base_q + 1], 32'd1);
            chk("t2_grant2", grant_q[base_q + 2], 32'd0);
            chk("t2_grant3", grant_q[base_q + 3], 32'd1);
        end

        // AW ready delayed by three cycles, W immediate
        aw_delay = 3; w_delay = 0;
        base_aw = aw_cycles; base_w = w_cycles; base_b = b_hs;
        set_req(1'b1, 1'b1, 1'b1, 1'b1);
        send();
        wait_done();
        chk("t3_awaddr",   seen_addr, 32'h0200_C004);
        chk("t3_aw_cycles", aw_cycles - base_aw, 32'd4);
        chk("t3_w_cycles",  w_cycles - base_w,   32'd1);
        chk("t3_b_count",   b_hs - base_b,       32'd1);
        aw_delay = 0;

        // SLVERR response on a supervisor clear
        b_code = 2'b10;
        base_r1 = rsp1_cnt;
        set_req(1'b1, 1'b0, 1'b1, 1'b0);
        send();
        wait_done();
        chk("t4_awaddr",  seen_addr,  32'h0200_C000);
        chk("t4_wdata",   seen_wdata, 32'h0);
        chk("t4_rsp_cnt", rsp1_cnt - base_r1, 32'd1);
        chk("t4_err",     {31'b0, err1_seen}, 32'h1);
        b_code = 2'b00;

        // Reset while waiting for B abandons the transaction
        b_delay = 6;
        base_r1 = rsp0_cnt + rsp1_cnt;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        send();
        begin
            int k;
            k = 0;
            while (!bready && k < 20) begin step(1); k++; end
            chk("t5_reached_resp", {31'b0, bready}, 32'h1);
        end
        areset = 1'b1;
        step(1);
        areset = 1'b0;
        chk("t5_awvalid", {31'b0, awvalid}, 32'h0);
        chk("t5_wvalid",  {31'b0, wvalid},  32'h0);
        chk("t5_bready",  {31'b0, bready},  32'h0);
        step(8);
        chk("t5_no_rsp", rsp0_cnt + rsp1_cnt - base_r1, 32'd0);
        b_delay = 0;
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        send();
        wait_done();
        chk("t5_next_addr",    seen_addr, 32'h0200_0004);
        chk("t5_next_latency", t_rsp1 - t_grant, 32'd3);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
